// File: rtl/vc_wrr_arbiter_pkg.sv
// Shared definitions for the VC weighted round-robin drain arbiter:
// default parameters, VC identifiers and FSM state encodings.
package vc_wrr_arbiter_pkg;

    localparam int BW_DEF     = 16;
    localparam int WEIGHT_DEF = 4;
    localparam int CNT_W_DEF  = 3;

    localparam logic VC0 = 1'b0;
    localparam logic VC1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

endpackage

// File: rtl/vc_wrr_arbiter_if.sv
// Bundle of the VC FIFO read side and the egress FIFO write side seen by the arbiter.
// master = arbiter, slave = FIFO side.
interface vc_wrr_arbiter_if #(
    parameter int BW = 16
);
    logic [BW-1:0] vc0_data;
    logic          vc0_empty;
    logic [BW-1:0] vc1_data;
    logic          vc1_empty;
    logic          out_almost_full;
    logic          out_full;
    logic          vc0_rd;
    logic          vc1_rd;
    logic          out_wr;
    logic [BW-1:0] out_data;
    logic          out_vc;
    logic          error_output;

    modport master (
        input  vc0_data, vc0_empty, vc1_data, vc1_empty, out_almost_full, out_full,
        output vc0_rd, vc1_rd, out_wr, out_data, out_vc, error_output
    );

    modport slave (
        output vc0_data, vc0_empty, vc1_data, vc1_empty, out_almost_full, out_full,
        input  vc0_rd, vc1_rd, out_wr, out_data, out_vc, error_output
    );

endinterface

// File: rtl/vc_wrr_arbiter.sv
// Drains two VC FIFOs into one egress FIFO with weighted round-robin.
// VC0 gets up to WEIGHT back-to-back pops while VC1 waits, then VC1 gets one.
// Pop in cycle N, read data captured at the end of N+1, out_wr visible in N+2.
//
// state | meaning
// IDLE  | both VC FIFOs empty, nothing to pop
// RUN   | data pending and egress has room, pops are being issued
// STALL | data pending but egress almost full, no pops
module vc_wrr_arbiter
    import vc_wrr_arbiter_pkg::*;
#(
    parameter int BW     = BW_DEF,
    parameter int WEIGHT = WEIGHT_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    vc_wrr_arbiter_if.master  bus
);

    localparam logic [CNT_W-1:0] WEIGHT_C = CNT_W'(WEIGHT);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              rd0;
    logic              rd1;
    logic              any_data;
    logic              pend_v;
    logic              pend_vc;
    logic              out_wr_r;
    logic [BW-1:0]     out_data_r;
    logic              out_vc_r;
    logic              err_r;

    assign any_data = !bus.vc0_empty || !bus.vc1_empty;

    // Grant: at most one pop per cycle; almost_full margin covers the two words in flight.
    always_comb begin
        rd0 = 1'b0;
        rd1 = 1'b0;
        if (!reset && !bus.out_almost_full) begin
            if (!bus.vc0_empty && (bus.vc1_empty || cnt < WEIGHT_C)) begin
                rd0 = 1'b1;
            end else if (!bus.vc1_empty) begin
                rd1 = 1'b1;
            end
        end
    end

    // Consecutive-VC0 counter; only counts while VC1 is waiting, saturates at WEIGHT.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (rd0) begin
            if (bus.vc1_empty) begin
                cnt <= '0;
            end else if (cnt != WEIGHT_C) begin
                cnt <= cnt + 1'b1;
            end
        end else if (rd1) begin
            cnt <= '0;
        end
    end

    // Pending stage: remembers which VC was popped so its data can be taken next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_v  <= 1'b0;
            pend_vc <= VC0;
        end else begin
            pend_v  <= rd0 || rd1;
            pend_vc <= rd1 ? VC1 : VC0;
        end
    end

    // Output register: push the captured word unless egress is full, in which case drop it.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_wr_r   <= 1'b0;
            out_data_r <= '0;
            out_vc_r   <= VC0;
        end else begin
            out_wr_r <= pend_v && !bus.out_full;
            if (pend_v && !bus.out_full) begin
                out_data_r <= (pend_vc == VC1) ? bus.vc1_data : bus.vc0_data;
                out_vc_r   <= pend_vc;
            end
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (pend_v && bus.out_full) begin
            err_r <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; empty flags already reflect the pop made on the previous edge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_data) begin
                    state_nxt = bus.out_almost_full ? STALL : RUN;
                end
            end
            RUN: begin
                if (bus.out_almost_full) begin
                    state_nxt = STALL;
                end else if (!any_data) begin
                    state_nxt = IDLE;
                end
            end
            STALL: begin
                if (!any_data) begin
                    state_nxt = IDLE;
                end else if (!bus.out_almost_full) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.vc0_rd       = rd0;
    assign bus.vc1_rd       = rd1;
    assign bus.out_wr       = out_wr_r;
    assign bus.out_data     = out_data_r;
    assign bus.out_vc       = out_vc_r;
    assign bus.error_output = err_r;

endmodule

// File: tb/tb_vc_wrr_arbiter.sv
// Directed bench for vc_wrr_arbiter: behavioural VC FIFOs feed the arbiter,
// egress writes are collected and compared with hand-computed streams.
module tb_vc_wrr_arbiter;
    import vc_wrr_arbiter_pkg::*;

    localparam int BW = 16;

    logic clk = 1'b0;
    logic reset;

    vc_wrr_arbiter_if #(.BW(BW)) bus ();

    vc_wrr_arbiter #(.BW(BW), .WEIGHT(4), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [BW-1:0] q0[$];
    logic [BW-1:0] q1[$];
    logic [16:0]   obs_q[$];
    logic [16:0]   exp_q[$];
    int n_vec  = 0;
    int n_miss = 0;
    int cnum   = 0;
    int rd0_n, rd1_n, first_rd, last_rd, first_wr, n_before;

    logic [15:0] t2_words [7] = '{16'h0A, 16'h0B, 16'h0C, 16'h0D, 16'h0E, 16'h0F, 16'h09};
    logic [16:0] t3_exp [10]  = '{17'h00001, 17'h00002, 17'h00003, 17'h00004, 17'h10081,
                                 17'h00005, 17'h00006, 17'h00007, 17'h00008, 17'h10082};
    logic [16:0] t6_exp [5]   = '{17'h10061, 17'h10062, 17'h10064, 17'h10065, 17'h10066};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample pops/writes at negedge, FIFO model reacts just after posedge.
    task automatic cyc();
        logic p0, p1;
        @(negedge clk);
        p0 = bus.vc0_rd;
        p1 = bus.vc1_rd;
        if (p0) chk("rd0_while_empty", 32'(bus.vc0_empty), 32'd0);
        if (p1) chk("rd1_while_empty", 32'(bus.vc1_empty), 32'd0);
        if (p0 || p1) begin
            if (first_rd < 0) first_rd = cnum;
            last_rd = cnum;
        end
        if (p0) rd0_n++;
        if (p1) rd1_n++;
        if (bus.out_wr) begin
            obs_q.push_back({bus.out_vc, bus.out_data});
            if (first_wr < 0) first_wr = cnum;
        end
        @(posedge clk);
        #1;
        cnum++;
        if (p0 && q0.size() > 0) bus.vc0_data = q0.pop_front();
        if (p1 && q1.size() > 0) bus.vc1_data = q1.pop_front();
        bus.vc0_empty = (q0.size() == 0);
        bus.vc1_empty = (q1.size() == 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic clear_stats();
        obs_q.delete();
        exp_q.delete();
        rd0_n    = 0;
        rd1_n    = 0;
        first_rd = -1;
        last_rd  = -1;
        first_wr = -1;
    endtask

    task automatic load0(input logic [BW-1:0] w);
        q0.push_back(w);
        bus.vc0_empty = 1'b0;
    endtask

    task automatic load1(input logic [BW-1:0] w);
        q1.push_back(w);
        bus.vc1_empty = 1'b0;
    endtask

    task automatic cmp_stream(input string tag);
        logic [16:0] got;
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < obs_q.size()) ? obs_q[i] : 17'h1FFFF;
            chk(tag, 32'(got), 32'(exp_q[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset               = 1'b1;
        bus.vc0_data        = '0;
        bus.vc1_data        = '0;
        bus.vc0_empty       = 1'b1;
        bus.vc1_empty       = 1'b1;
        bus.out_almost_full = 1'b0;
        bus.out_full        = 1'b0;
        clear_stats();

        // 1: reset held two clocks with both FIFOs loaded
        load0(16'hAA);
        load1(16'hBB);
        run(2);
        chk("rst_vc0_rd", 32'(bus.vc0_rd), 32'd0);
        chk("rst_vc1_rd", 32'(bus.vc1_rd), 32'd0);
        chk("rst_out_wr", 32'(bus.out_wr), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_error", 32'(bus.error_output), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        q0.delete();
        q1.delete();
        bus.vc0_empty = 1'b1;
        bus.vc1_empty = 1'b1;
        reset = 1'b0;
        run(2);

        // 2: VC0 only, seven words
        clear_stats();
        for (int i = 0; i < 7; i++) begin
            load0(t2_words[i]);
            exp_q.push_back({VC0, t2_words[i]});
        end
        run(12);
        chk("t2_rd0_count", 32'(rd0_n), 32'd7);
        chk("t2_rd1_count", 32'(rd1_n), 32'd0);
        chk("t2_rd_span", 32'(last_rd - first_rd), 32'd6);
        chk("t2_latency", 32'(first_wr - first_rd), 32'd2);
        cmp_stream("t2_stream");

        // 3: weighted round-robin, WEIGHT = 4
        clear_stats();
        for (int i = 1; i <= 8; i++) load0(16'(i));
        load1(16'h81);
        load1(16'h82);
        for (int i = 0; i < 10; i++) exp_q.push_back(t3_exp[i]);
        run(16);
        chk("t3_rd0_count", 32'(rd0_n), 32'd8);
        chk("t3_rd1_count", 32'(rd1_n), 32'd2);
        cmp_stream("t3_stream");

        // 4: almost_full mid-burst, then release
        clear_stats();
        for (int i = 0; i < 10; i++) begin
            load0(16'(16'h20 + i));
            exp_q.push_back({VC0, 16'(16'h20 + i)});
        end
        run(4);
        chk("t4_state_run", 32'(dut.state), 32'(RUN));
        bus.out_almost_full = 1'b1;
        #1;
        chk("t4_rd_drop", 32'(bus.vc0_rd), 32'd0);
        n_before = obs_q.size();
        run(6);
        chk("t4_wr_in_stall", 32'(obs_q.size() - n_before), 32'd2);
        chk("t4_rd_in_stall", 32'(rd0_n), 32'd4);
        chk("t4_state_stall", 32'(dut.state), 32'(STALL));
        bus.out_almost_full = 1'b0;
        cyc();
        chk("t4_state_resume", 32'(dut.state), 32'(RUN));
        run(12);
        cmp_stream("t4_stream");

        // 5: overflow while a word sits in the stage
        clear_stats();
        load0(16'h55);
        cyc();
        bus.out_full = 1'b1;
        cyc();
        chk("t5_out_wr", 32'(bus.out_wr), 32'd0);
        chk("t5_error_set", 32'(bus.error_output), 32'd1);
        bus.out_full = 1'b0;
        run(10);
        chk("t5_error_sticky", 32'(bus.error_output), 32'd1);
        chk("t5_dropped", 32'(obs_q.size()), 32'd0);
        reset = 1'b1;
        cyc();
        chk("t5_error_clear", 32'(bus.error_output), 32'd0);
        reset = 1'b0;
        run(2);

        // 6: reset after three of six VC1 pops
        clear_stats();
        for (int i = 0; i < 6; i++) load1(16'(16'h61 + i));
        for (int i = 0; i < 5; i++) exp_q.push_back(t6_exp[i]);
        run(3);
        reset = 1'b1;
        #1;
        chk("t6_rd_in_reset", 32'(bus.vc1_rd), 32'd0);
        cyc();
        chk("t6_out_wr", 32'(bus.out_wr), 32'd0);
        chk("t6_out_data", 32'(bus.out_data), 32'd0);
        chk("t6_out_vc", 32'(bus.out_vc), 32'd0);
        chk("t6_cnt", 32'(dut.cnt), 32'd0);
        chk("t6_state", 32'(dut.state), 32'(IDLE));
        reset = 1'b0;
        run(8);
        chk("t6_rd1_count", 32'(rd1_n), 32'd6);
        cmp_stream("t6_stream");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
